// File: rtl/vga_pkg.sv
// Shared raster timing constants for the 640x480 @ 60 Hz display path.
// Holds the default porch/sync/active sizes, the derived line and frame
// totals, and the scan-address widths that every renderer also uses.
package vga_pkg;

  localparam int unsigned DEF_H_ACTIVE   = 640;
  localparam int unsigned DEF_H_FP       = 16;
  localparam int unsigned DEF_H_SYNC     = 96;
  localparam int unsigned DEF_H_BP       = 48;
  localparam int unsigned DEF_V_ACTIVE   = 480;
  localparam int unsigned DEF_V_FP       = 10;
  localparam int unsigned DEF_V_SYNC     = 2;
  localparam int unsigned DEF_V_BP       = 33;
  localparam int unsigned DEF_FRESH_LINE = 480;

  localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Scan address widths shared with the renderers.
  localparam int unsigned ROW_W   = 9;
  localparam int unsigned COL_W   = 10;
  localparam int unsigned FRAME_W = 16;

endpackage

// File: rtl/vga_scan_timer_if.sv
// Scan-timing bundle from the raster timer to the renderers.
//   row_addr/col_addr : visible scan position (0 outside active area)
//   hs/vs             : active-low sync pulses
//   rdn               : active-low visible flag
//   fresh             : high for the whole frame-update line
//   frame_cnt         : frames completed since reset
interface vga_scan_timer_if;
  import vga_pkg::*;

  logic [ROW_W-1:0]   row_addr;
  logic [COL_W-1:0]   col_addr;
  logic               hs;
  logic               vs;
  logic               rdn;
  logic               fresh;
  logic [FRAME_W-1:0] frame_cnt;

  modport master (
    output row_addr, col_addr, hs, vs, rdn, fresh, frame_cnt
  );

  modport slave (
    input row_addr, col_addr, hs, vs, rdn, fresh, frame_cnt
  );

endinterface

// File: rtl/vga_scan_timer.sv
// Free-running VGA raster timer. One horizontal and one vertical counter
// drive registered decodes of sync, blanking, scan address and the
// once-per-frame fresh strobe; all outputs update on the same edge.
//   clk    : pixel clock
//   rst    : synchronous active-high reset
//   o_scan : scan-timing bundle (master side)
module vga_scan_timer
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter int unsigned FRESH_LINE = DEF_FRESH_LINE
) (
  input  logic              clk,
  input  logic              rst,
  vga_scan_timer_if.master  o_scan
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_CW    = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int unsigned V_CW    = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  localparam logic [H_CW-1:0] H_LAST    = H_CW'(H_TOTAL - 1);
  localparam logic [V_CW-1:0] V_LAST    = V_CW'(V_TOTAL - 1);
  localparam logic [H_CW-1:0] H_ACT_C   = H_CW'(H_ACTIVE);
  localparam logic [V_CW-1:0] V_ACT_C   = V_CW'(V_ACTIVE);
  localparam logic [H_CW-1:0] H_SYNC_LO = H_CW'(H_ACTIVE + H_FP);
  localparam logic [H_CW-1:0] H_SYNC_HI = H_CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [V_CW-1:0] V_SYNC_LO = V_CW'(V_ACTIVE + V_FP);
  localparam logic [V_CW-1:0] V_SYNC_HI = V_CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [V_CW-1:0] FRESH_C   = V_CW'(FRESH_LINE);

  logic [H_CW-1:0]    r_hcnt;
  logic [V_CW-1:0]    r_vcnt;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic [ROW_W-1:0]   r_row_addr;
  logic [COL_W-1:0]   r_col_addr;
  logic               r_hs;
  logic               r_vs;
  logic               r_rdn;
  logic               r_fresh;

  logic               w_h_wrap;
  logic               w_v_wrap;
  logic               w_frame_inc;
  logic [H_CW-1:0]    w_hcnt_nxt;
  logic [V_CW-1:0]    w_vcnt_nxt;
  logic               w_h_act;
  logic               w_v_act;
  logic [ROW_W-1:0]   w_row_nxt;
  logic [COL_W-1:0]   w_col_nxt;
  logic               w_hs_nxt;
  logic               w_vs_nxt;
  logic               w_rdn_nxt;
  logic               w_fresh_nxt;

  // Next counter position; vcnt steps only when hcnt wraps.
  always_comb begin
    w_h_wrap    = (r_hcnt == H_LAST);
    w_v_wrap    = (r_vcnt == V_LAST);
    w_frame_inc = w_h_wrap & w_v_wrap;
    w_hcnt_nxt  = w_h_wrap ? '0 : r_hcnt + H_CW'(1);
    w_vcnt_nxt  = r_vcnt;
    if (w_h_wrap) begin
      w_vcnt_nxt = w_v_wrap ? '0 : r_vcnt + V_CW'(1);
    end
  end

  // Decode from the next position so outputs land with the counters.
  always_comb begin
    w_h_act     = (w_hcnt_nxt < H_ACT_C);
    w_v_act     = (w_vcnt_nxt < V_ACT_C);
    w_col_nxt   = w_h_act ? COL_W'(w_hcnt_nxt) : '0;
    w_row_nxt   = w_v_act ? ROW_W'(w_vcnt_nxt) : '0;
    w_hs_nxt    = ~((w_hcnt_nxt >= H_SYNC_LO) && (w_hcnt_nxt <= H_SYNC_HI));
    w_vs_nxt    = ~((w_vcnt_nxt >= V_SYNC_LO) && (w_vcnt_nxt <= V_SYNC_HI));
    w_rdn_nxt   = ~(w_h_act & w_v_act);
    w_fresh_nxt = (w_vcnt_nxt == FRESH_C);
  end

  // Counter and output registers; reset lands on the (0,0) decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hcnt      <= '0;
      r_vcnt      <= '0;
      r_frame_cnt <= '0;
      r_row_addr  <= '0;
      r_col_addr  <= '0;
      r_hs        <= 1'b1;
      r_vs        <= 1'b1;
      r_rdn       <= 1'b0;
      r_fresh     <= 1'b0;
    end else begin
      r_hcnt     <= w_hcnt_nxt;
      r_vcnt     <= w_vcnt_nxt;
      if (w_frame_inc) begin
        r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
      end
      r_row_addr <= w_row_nxt;
      r_col_addr <= w_col_nxt;
      r_hs       <= w_hs_nxt;
      r_vs       <= w_vs_nxt;
      r_rdn      <= w_rdn_nxt;
      r_fresh    <= w_fresh_nxt;
    end
  end

  assign o_scan.row_addr  = r_row_addr;
  assign o_scan.col_addr  = r_col_addr;
  assign o_scan.hs        = r_hs;
  assign o_scan.vs        = r_vs;
  assign o_scan.rdn       = r_rdn;
  assign o_scan.fresh     = r_fresh;
  assign o_scan.frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_vga_scan_timer.sv
// Scoreboard bench for vga_scan_timer: a reduced-timing instance exercises
// whole frames, mid-frame reset and frame_cnt wrap; a default-timing
// instance sharing clk/rst covers the first lines at 640x480 sizes.
module tb_vga_scan_timer;
  import vga_pkg::*;

  // Reduced timing: 25-pixel lines, 19-line frames.
  localparam int S_HA = 16, S_HF = 2, S_HS = 4, S_HB = 3;
  localparam int S_VA = 12, S_VF = 2, S_VS = 2, S_VB = 3, S_FL = 12;
  localparam int S_FT = 475;           // 25 * 19
  // Per-frame totals for the reduced timing.
  localparam int S_HS_LOW   = 76;      // 4 pixels * 19 lines
  localparam int S_VS_LOW   = 50;      // 2 lines * 25 pixels
  localparam int S_RDN_LOW  = 192;     // 16 * 12
  localparam int S_FRESH_HI = 25;      // one line

  typedef struct packed {
    logic [8:0]  row;
    logic [9:0]  col;
    logic        hs;
    logic        vs;
    logic        rdn;
    logic        fresh;
    logic [15:0] frame;
  } obs_t;

  typedef struct {
    obs_t s;
    obs_t d;
    int   t;
    bit   frame_end;
    bit   is_rst;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_scan_timer_if s_if ();
  vga_scan_timer_if d_if ();

  vga_scan_timer #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .FRESH_LINE(S_FL)
  ) dut_s (
    .clk    (clk),
    .rst    (rst),
    .o_scan (s_if)
  );

  vga_scan_timer dut_d (
    .clk    (clk),
    .rst    (rst),
    .o_scan (d_if)
  );

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   t      = 0;
  int   fb_s   = 0;
  bit   done   = 1'b0;

  // Expected outputs t cycles after the reset edge, from absolute time.
  function automatic obs_t model(input int tt, input int fbase,
                                 input int ha, input int hf, input int hs, input int hb,
                                 input int va, input int vf, input int vs, input int vb,
                                 input int fl);
    obs_t o;
    int ht, vt, h, v;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    h  = tt % ht;
    v  = (tt / ht) % vt;
    o.col   = (h < ha) ? 10'(h) : 10'd0;
    o.row   = (v < va) ? 9'(v) : 9'd0;
    o.hs    = !((h >= ha + hf) && (h < ha + hf + hs));
    o.vs    = !((v >= va + vf) && (v < va + vf + vs));
    o.rdn   = !((h < ha) && (v < va));
    o.fresh = (v == fl);
    o.frame = 16'(fbase + tt / (ht * vt));
    return o;
  endfunction

  // One clock of stimulus; called just after a falling edge.
  task automatic step(input logic r);
    exp_t e;
    rst = r;
    if (r) begin
      t    = 0;
      fb_s = 0;
    end else begin
      t = t + 1;
    end
    e.s = model(t, fb_s, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, S_FL);
    e.d = model(t, 0, 640, 16, 96, 48, 480, 10, 2, 33, 480);
    e.t = t;
    e.is_rst    = r;
    e.frame_end = !r && (t > 0) && (t % S_FT == 0);
    q.push_back(e);
    @(negedge clk);
  endtask

  // Stimulus
  initial begin
    @(negedge clk);
    repeat (3) step(1'b1);
    // Two full frames plus a few cycles.
    repeat (2 * S_FT + 5) step(1'b0);
    // Advance to hcnt=20, vcnt=15 (hs and vs both low), then reset one cycle.
    while (t != 2 * S_FT + 395) step(1'b0);
    step(1'b1);
    // Approach end of frame, preload frame_cnt to 0xFFFF, watch it wrap.
    while (t != S_FT - 3) step(1'b0);
    force dut_s.r_frame_cnt = 16'hFFFF;
    fb_s = 16'hFFFF;
    step(1'b0);
    release dut_s.r_frame_cnt;
    repeat (12) step(1'b0);
    repeat (3) @(negedge clk);
    done = 1'b1;
  end

  // Monitor
  obs_t a_s, a_d;
  exp_t em;
  int   c_hs, c_vs, c_rdn, c_fr;

  initial begin
    c_hs = 0; c_vs = 0; c_rdn = 0; c_fr = 0;
    while (!done) begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        em  = q.pop_front();
        a_s = '{row: s_if.row_addr, col: s_if.col_addr, hs: s_if.hs, vs: s_if.vs,
                rdn: s_if.rdn, fresh: s_if.fresh, frame: s_if.frame_cnt};
        a_d = '{row: d_if.row_addr, col: d_if.col_addr, hs: d_if.hs, vs: d_if.vs,
                rdn: d_if.rdn, fresh: d_if.fresh, frame: d_if.frame_cnt};
        checks++;
        if (a_s !== em.s) begin
          errors++;
          $display("FAIL small_scan t=%0d got row=%0d col=%0d hs=%b vs=%b rdn=%b fresh=%b frame=%h exp row=%0d col=%0d hs=%b vs=%b rdn=%b fresh=%b frame=%h",
                   em.t, a_s.row, a_s.col, a_s.hs, a_s.vs, a_s.rdn, a_s.fresh, a_s.frame,
                   em.s.row, em.s.col, em.s.hs, em.s.vs, em.s.rdn, em.s.fresh, em.s.frame);
        end
        checks++;
        if (a_d !== em.d) begin
          errors++;
          $display("FAIL default_scan t=%0d got row=%0d col=%0d hs=%b vs=%b rdn=%b fresh=%b frame=%h exp row=%0d col=%0d hs=%b vs=%b rdn=%b fresh=%b frame=%h",
                   em.t, a_d.row, a_d.col, a_d.hs, a_d.vs, a_d.rdn, a_d.fresh, a_d.frame,
                   em.d.row, em.d.col, em.d.hs, em.d.vs, em.d.rdn, em.d.fresh, em.d.frame);
        end
        // Per-frame totals over a complete frame since the last reset.
        if (em.frame_end) begin
          checks++;
          if (c_hs != S_HS_LOW) begin
            errors++;
            $display("FAIL hs_low_per_frame got %0d exp %0d", c_hs, S_HS_LOW);
          end
          checks++;
          if (c_vs != S_VS_LOW) begin
            errors++;
            $display("FAIL vs_low_per_frame got %0d exp %0d", c_vs, S_VS_LOW);
          end
          checks++;
          if (c_rdn != S_RDN_LOW) begin
            errors++;
            $display("FAIL rdn_low_per_frame got %0d exp %0d", c_rdn, S_RDN_LOW);
          end
          checks++;
          if (c_fr != S_FRESH_HI) begin
            errors++;
            $display("FAIL fresh_high_per_frame got %0d exp %0d", c_fr, S_FRESH_HI);
          end
        end
        if (em.is_rst || em.frame_end) begin
          c_hs = 0; c_vs = 0; c_rdn = 0; c_fr = 0;
        end
        c_hs  += (a_s.hs    == 1'b0) ? 1 : 0;
        c_vs  += (a_s.vs    == 1'b0) ? 1 : 0;
        c_rdn += (a_s.rdn   == 1'b0) ? 1 : 0;
        c_fr  += (a_s.fresh == 1'b1) ? 1 : 0;
      end
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d pending exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_scan_timer.md
# vga_scan_timer

Generates the 640×480 @ 60 Hz raster timing for the game display. It sits directly upstream of the ground, dinosaur, obstacle and score renderers. Every pixel clock it supplies the current scan position (`row_addr`, `col_addr`), the VGA sync pulses, a blanking flag, and `fresh`, the once-per-frame strobe on whose falling edge game objects advance. All outputs come from one pair of free-running counters and are mutually skew-free.

## Interface

**Parameters**
- `H_ACTIVE`, default 640: visible pixels per line.
- `H_FP`, default 16: horizontal front porch, in pixels.
- `H_SYNC`, default 96: horizontal sync width, in pixels.
- `H_BP`, default 48: horizontal back porch, in pixels.
- `V_ACTIVE`, default 480: visible lines per frame.
- `V_FP`, default 10: vertical front porch, in lines.
- `V_SYNC`, default 2: vertical sync width, in lines.
- `V_BP`, default 33: vertical back porch, in lines.
- `FRESH_LINE`, default 480: the single line during which `fresh` is high. Must lie in vertical blanking.

**Ports**
- `clk`, in, 1: pixel clock (25 MHz, driven from `clkdiv[1]` at top level).
- `rst`, in, 1: reset. Synchronous, active-high.
- `row_addr`, out, 9: visible row, 0..479. Forced to 0 outside vertical active.
- `col_addr`, out, 10: visible column, 0..639. Forced to 0 outside horizontal active.
- `hs`, out, 1: horizontal sync, active-low.
- `vs`, out, 1: vertical sync, active-low.
- `rdn`, out, 1: video blank, active-low. 0 means the pixel is visible.
- `fresh`, out, 1: high for the whole of line `FRESH_LINE`, low otherwise.
- `frame_cnt`, out, 16: frames completed since reset. Wraps modulo 2^16.

## Operation

**Counters**
- `hcnt` counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
- `vcnt` counts 0..V_TOTAL-1, where V_TOTAL = 525.
- `hcnt` increments every cycle. At H_TOTAL-1 it wraps to 0 and `vcnt` increments.
- `vcnt` wraps from V_TOTAL-1 to 0 on the same edge that `hcnt` wraps. That edge also increments `frame_cnt`.
- Both counters are 10 bits. The widths are fixed by localparams computed from the parameters.

**Decoded outputs.** Each output is a registered decode of the counter values it describes.
- `hs` = 0 iff `hcnt` ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656, 751].
- `vs` = 0 iff `vcnt` ∈ [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. [490, 491].
- `rdn` = 0 iff `hcnt` < H_ACTIVE and `vcnt` < V_ACTIVE.
- `col_addr` = `hcnt` when `hcnt` < H_ACTIVE, else 0.
- `row_addr` = `vcnt[8:0]` when `vcnt` < V_ACTIVE, else 0.
- `fresh` = 1 iff `vcnt` == FRESH_LINE.
  - Rising edge at the start of line 480; falling edge at the start of line 481.
  - Both edges therefore fall inside vertical blanking, so object state never changes mid-picture.

**Reset**
- Counters and `frame_cnt` are cleared to 0.
- Outputs take their decode for (0,0): `row_addr`=0, `col_addr`=0, `rdn`=0, `hs`=1, `vs`=1, `fresh`=0.
- A reset asserted mid-frame abandons the frame. No partial sync pulse is stretched. `hs`/`vs` return to 1 on the first edge with `rst` high.

## Timing

- The decoded outputs and the counters they describe update on the same `clk` edge.
  - Decode uses next-state counter values, so zero cycles of latency relative to the counters.
  - Zero cycles of skew between any two outputs.
- The first edge with `rst` low advances the position to (hcnt=1, vcnt=0).
- Line period: 800 cycles. `hs` low for exactly 96 consecutive cycles per line.
- Frame period: 420 000 cycles.
  - `vs` low for exactly 1 600 consecutive cycles.
  - `fresh` high for exactly 800 consecutive cycles.
- `rdn` low for 640 consecutive cycles on each of lines 0..479. That gives 307 200 visible cycles per frame.
- `frame_cnt` increments on the edge where (799,524) → (0,0). At 0xFFFF that edge wraps it to 0x0000.
- Downstream renderers register their pixel one cycle after `row_addr`/`col_addr`. The top level delays `hs`/`vs`/`rdn` by one cycle to match; that delay is not done in this block.

## Structure

- Shared package `vga_pkg` holds:
  - the default timing constants (the eight parameters above);
  - derived H_TOTAL/V_TOTAL;
  - the `row_addr`/`col_addr` widths, which are also used by all renderers.
- Single module, no sub-modules. The two counters plus the decode fit comfortably in one block.

## Test plan

- **Reset and first edge:** hold `rst` 3 cycles, then release → on release `row_addr`=0, `col_addr`=0, `rdn`=0, `hs`=1, `vs`=1, `fresh`=0, `frame_cnt`=0. One edge later `col_addr`=1.
- **Horizontal line:** run one line → `col_addr` ramps 0..639 then holds 0 for 160 cycles. `hs` falls 656 cycles after line start, rises 96 cycles later. The next line starts exactly 800 cycles after the previous one.
- **Full frame:** run 420 000 cycles →
  - `vs` low exactly 1 600 cycles, starting at line 490;
  - `rdn` low 307 200 cycles;
  - `frame_cnt` = 1.
- **fresh strobe:** run two frames → `fresh` high 800 cycles starting at line 480, falls at line 481. `row_addr` is 0 and `rdn` is 1 throughout the high interval.
- **Mid-frame reset:** assert `rst` one cycle at (hcnt=700, vcnt=491), while `hs` and `vs` are both low → next edge `hs`=1, `vs`=1, position (0,0), `frame_cnt`=0.
- **frame_cnt wrap:** force `frame_cnt` to 0xFFFF, run to the end of the frame → `frame_cnt` = 0x0000 at the (799,524)→(0,0) edge.
